// File: rtl/cmp_pkg.sv
// Shared types and constants for the compare issue path.
// Used by the operand issue stage and the compare unit.
package cmp_pkg;

   localparam int DATA_W     = 32;
   localparam int REG_N      = 32;
   localparam int REG_ADDR_W = 5;
   localparam int IMM_W      = 12;

   localparam logic [1:0] OP_SIGNED   = 2'b00;
   localparam logic [1:0] OP_UNSIGNED = 2'b01;

   localparam logic [DATA_W-1:0] CMP_FALSE = '0;
   localparam logic [DATA_W-1:0] CMP_TRUE  = DATA_W'(1);

   typedef struct packed {
      logic [DATA_W-1:0]     op_a;
      logic [DATA_W-1:0]     op_b;
      logic [1:0]            opcode;
      logic [REG_ADDR_W-1:0] rd;
   } issue_t;

   typedef enum logic [1:0] {
      OCC_EMPTY = 2'd0,
      OCC_ONE   = 2'd1,
      OCC_FULL  = 2'd2
   } occ_e;

   function automatic logic [DATA_W-1:0] sext_imm(
      input logic [IMM_W-1:0] imm
   );
      return {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
   endfunction

endpackage

// File: rtl/cmp_operand_issue_if.sv
// Decode-side and compare-side handshake bundle.
// master = upstream/consumer side, slave = issue stage.
interface cmp_operand_issue_if;
   import cmp_pkg::*;

   logic                  in_valid_i;
   logic                  in_ready_o;
   logic [REG_ADDR_W-1:0] in_rs1_i;
   logic [REG_ADDR_W-1:0] in_rs2_i;
   logic [IMM_W-1:0]      in_imm_i;
   logic                  in_use_imm_i;
   logic [1:0]            in_opcode_i;
   logic [REG_ADDR_W-1:0] in_rd_i;

   logic                  out_valid_o;
   logic                  out_ready_i;
   logic [DATA_W-1:0]     op_a_o;
   logic [DATA_W-1:0]     op_b_o;
   logic [1:0]            opcode_o;
   logic [REG_ADDR_W-1:0] rd_o;

   modport master (
      output in_valid_i, in_rs1_i, in_rs2_i, in_imm_i,
      output in_use_imm_i, in_opcode_i, in_rd_i, out_ready_i,
      input  in_ready_o, out_valid_o, op_a_o, op_b_o,
      input  opcode_o, rd_o
   );

   modport slave (
      input  in_valid_i, in_rs1_i, in_rs2_i, in_imm_i,
      input  in_use_imm_i, in_opcode_i, in_rd_i, out_ready_i,
      output in_ready_o, out_valid_o, op_a_o, op_b_o,
      output opcode_o, rd_o
   );

endinterface

// File: rtl/cmp_regfile.sv
// 32x32 register file, two async read ports with write bypass.
// x0 is hardwired to zero.
module cmp_regfile
   import cmp_pkg::*;
(
   input  logic                  clk_i,
   input  logic                  rst_n_i,
   input  logic                  we_i,
   input  logic [REG_ADDR_W-1:0] waddr_i,
   input  logic [DATA_W-1:0]     wdata_i,
   input  logic [REG_ADDR_W-1:0] raddr_a_i,
   output logic [DATA_W-1:0]     rdata_a_o,
   input  logic [REG_ADDR_W-1:0] raddr_b_i,
   output logic [DATA_W-1:0]     rdata_b_o
);

   logic [DATA_W-1:0] regs_q [REG_N];
   logic              wr_en;

   assign wr_en = we_i && (waddr_i != '0);

   // Write port; x0 is never written so it stays zero.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         for (int i = 0; i < REG_N; i++) begin
            regs_q[i] <= '0;
         end
      end else if (wr_en) begin
         regs_q[waddr_i] <= wdata_i;
      end
   end

   // Read ports: x0 first, then same-cycle bypass, then array.
   always_comb begin
      rdata_a_o = regs_q[raddr_a_i];
      rdata_b_o = regs_q[raddr_b_i];
      if (raddr_a_i == '0) begin
         rdata_a_o = '0;
      end else if (wr_en && (waddr_i == raddr_a_i)) begin
         rdata_a_o = wdata_i;
      end
      if (raddr_b_i == '0) begin
         rdata_b_o = '0;
      end else if (wr_en && (waddr_i == raddr_b_i)) begin
         rdata_b_o = wdata_i;
      end
   end

endmodule

// File: rtl/cmp_operand_issue.sv
// Operand issue stage feeding the compare unit.
// Output register plus one-entry skid, operands captured at accept.
module cmp_operand_issue
   import cmp_pkg::*;
(
   input  logic                  clk_i,
   input  logic                  rst_n_i,
   input  logic                  flush_i,
   input  logic                  wb_we_i,
   input  logic [REG_ADDR_W-1:0] wb_addr_i,
   input  logic [DATA_W-1:0]     wb_data_i,
   cmp_operand_issue_if.slave    bus
);

   occ_e              state_q;
   issue_t            out_q;
   issue_t            skid_q;
   issue_t            new_w;
   logic [DATA_W-1:0] rs1_val;
   logic [DATA_W-1:0] rs2_val;
   logic              in_ready;
   logic              in_xfer;
   logic              out_xfer;

   cmp_regfile u_rf (
      .clk_i     (clk_i),
      .rst_n_i   (rst_n_i),
      .we_i      (wb_we_i),
      .waddr_i   (wb_addr_i),
      .wdata_i   (wb_data_i),
      .raddr_a_i (bus.in_rs1_i),
      .rdata_a_o (rs1_val),
      .raddr_b_i (bus.in_rs2_i),
      .rdata_b_o (rs2_val)
   );

   assign new_w.op_a   = rs1_val;
   assign new_w.op_b   = bus.in_use_imm_i ? sext_imm(bus.in_imm_i)
                                          : rs2_val;
   assign new_w.opcode = bus.in_opcode_i;
   assign new_w.rd     = bus.in_rd_i;

   assign in_ready = (state_q != OCC_FULL);
   assign in_xfer  = bus.in_valid_i && in_ready && !flush_i;
   assign out_xfer = (state_q != OCC_EMPTY) && bus.out_ready_i;

   // Occupancy FSM: route accepted entries into OUT or SKID.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q <= OCC_EMPTY;
         out_q   <= '0;
         skid_q  <= '0;
      end else if (flush_i) begin
         state_q <= OCC_EMPTY;
      end else begin
         unique case (state_q)
            OCC_EMPTY: begin
               if (in_xfer) begin
                  out_q   <= new_w;
                  state_q <= OCC_ONE;
               end
            end
            OCC_ONE: begin
               if (in_xfer && out_xfer) begin
                  out_q <= new_w;
               end else if (in_xfer) begin
                  skid_q  <= new_w;
                  state_q <= OCC_FULL;
               end else if (out_xfer) begin
                  state_q <= OCC_EMPTY;
               end
            end
            OCC_FULL: begin
               if (out_xfer) begin
                  out_q   <= skid_q;
                  state_q <= OCC_ONE;
               end
            end
            default: state_q <= OCC_EMPTY;
         endcase
      end
   end

   assign bus.in_ready_o  = in_ready;
   assign bus.out_valid_o = (state_q != OCC_EMPTY);
   assign bus.op_a_o      = out_q.op_a;
   assign bus.op_b_o      = out_q.op_b;
   assign bus.opcode_o    = out_q.opcode;
   assign bus.rd_o        = out_q.rd;

endmodule

// File: tb/tb_cmp_operand_issue.sv
// Bench for cmp_operand_issue: directed stimulus, queue scoreboard.
// Monitor pops an expected payload on every output transfer.
module tb_cmp_operand_issue;
   import cmp_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        flush = 1'b0;
   logic        wb_we = 1'b0;
   logic [4:0]  wb_addr = '0;
   logic [31:0] wb_data = '0;

   cmp_operand_issue_if bus();

   cmp_operand_issue dut (
      .clk_i     (clk),
      .rst_n_i   (rst_n),
      .flush_i   (flush),
      .wb_we_i   (wb_we),
      .wb_addr_i (wb_addr),
      .wb_data_i (wb_data),
      .bus       (bus)
   );

   always #5 clk = ~clk;

   int          total = 0;
   int          bad = 0;
   issue_t      exp_q[$];
   logic [31:0] mreg [32];

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: compare every output transfer against the queue head.
   always @(negedge clk) begin
      if (rst_n && bus.out_valid_o && bus.out_ready_i) begin
         issue_t got;
         issue_t e;
         got.op_a   = bus.op_a_o;
         got.op_b   = bus.op_b_o;
         got.opcode = bus.opcode_o;
         got.rd     = bus.rd_o;
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_out: got %h expected none", got);
         end else begin
            e = exp_q.pop_front();
            if (got !== e) begin
               bad++;
               $display("FAIL out_payload: got %h expected %h", got, e);
            end
         end
      end
   end

   function automatic logic [31:0] model_rd(input logic [4:0] rs);
      if (rs == 5'd0) return 32'h0;
      if (wb_we && wb_addr == rs) return wb_data;
      return mreg[rs];
   endfunction

   task automatic step();
      @(negedge clk);
      if (bus.in_valid_i && bus.in_ready_o && !flush) begin
         issue_t e;
         e.op_a   = model_rd(bus.in_rs1_i);
         e.op_b   = bus.in_use_imm_i ? sext_imm(bus.in_imm_i)
                                     : model_rd(bus.in_rs2_i);
         e.opcode = bus.in_opcode_i;
         e.rd     = bus.in_rd_i;
         exp_q.push_back(e);
      end
      @(posedge clk);
      if (rst_n && wb_we && wb_addr != 5'd0) mreg[wb_addr] = wb_data;
      #1;
   endtask

   task automatic drive(input logic v, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [11:0] imm,
                        input logic ui, input logic [1:0] opc,
                        input logic [4:0] rd);
      bus.in_valid_i   = v;
      bus.in_rs1_i     = rs1;
      bus.in_rs2_i     = rs2;
      bus.in_imm_i     = imm;
      bus.in_use_imm_i = ui;
      bus.in_opcode_i  = opc;
      bus.in_rd_i      = rd;
   endtask

   task automatic wb(input logic we, input logic [4:0] a,
                     input logic [31:0] d);
      wb_we   = we;
      wb_addr = a;
      wb_data = d;
   endtask

   task automatic idle();
      drive(1'b0, 5'd0, 5'd0, 12'h0, 1'b0, 2'b00, 5'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < 32; i++) mreg[i] = '0;
      idle();
      bus.out_ready_i = 1'b0;

      // Reset state
      #12;
      chk("rst_out_valid", 32'(bus.out_valid_o), 32'd0);
      chk("rst_in_ready", 32'(bus.in_ready_o), 32'd1);
      chk("rst_op_a", bus.op_a_o, 32'h0);
      chk("rst_op_b", bus.op_b_o, 32'h0);
      chk("rst_rd", 32'(bus.rd_o), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Register path and immediate sign extension
      wb(1'b1, 5'd5, 32'hFFFF_FFF0);
      step();
      wb(1'b1, 5'd6, 32'h0000_0010);
      step();
      wb(1'b0, 5'd0, 32'h0);
      bus.out_ready_i = 1'b1;
      drive(1'b1, 5'd5, 5'd6, 12'h0, 1'b0, 2'b00, 5'd7);
      step();
      chk("lat_out_valid", 32'(bus.out_valid_o), 32'd1);
      chk("reg_op_a", bus.op_a_o, 32'hFFFF_FFF0);
      chk("reg_op_b", bus.op_b_o, 32'h0000_0010);
      chk("reg_rd", 32'(bus.rd_o), 32'd7);
      drive(1'b1, 5'd5, 5'd6, 12'h800, 1'b1, 2'b01, 5'd8);
      step();
      chk("imm_op_b", bus.op_b_o, 32'hFFFF_F800);
      chk("imm_opcode", 32'(bus.opcode_o), 32'd1);
      idle();
      step();
      chk("drain_valid", 32'(bus.out_valid_o), 32'd0);

      // Same-cycle bypass
      wb(1'b1, 5'd3, 32'h0000_1234);
      drive(1'b1, 5'd3, 5'd0, 12'h0, 1'b0, 2'b00, 5'd9);
      step();
      wb(1'b0, 5'd0, 32'h0);
      chk("byp_op_a", bus.op_a_o, 32'h0000_1234);
      chk("x0_op_b", bus.op_b_o, 32'h0);
      idle();
      step();

      // x0 write ignored
      wb(1'b1, 5'd0, 32'h0000_DEAD);
      step();
      wb(1'b0, 5'd0, 32'h0);
      drive(1'b1, 5'd0, 5'd0, 12'h0, 1'b0, 2'b00, 5'd10);
      step();
      chk("x0_op_a", bus.op_a_o, 32'h0);
      idle();
      step();

      // Backpressure fills OUT then SKID
      bus.out_ready_i = 1'b0;
      drive(1'b1, 5'd5, 5'd0, 12'h0, 1'b0, 2'b00, 5'd1);
      step();
      chk("bp_ready_one", 32'(bus.in_ready_o), 32'd1);
      drive(1'b1, 5'd6, 5'd0, 12'h0, 1'b0, 2'b01, 5'd2);
      step();
      chk("bp_ready_full", 32'(bus.in_ready_o), 32'd0);
      drive(1'b1, 5'd3, 5'd0, 12'h0, 1'b0, 2'b00, 5'd3);
      step();
      chk("bp_ready_hold", 32'(bus.in_ready_o), 32'd0);
      chk("bp_hold_op_a", bus.op_a_o, 32'hFFFF_FFF0);
      chk("bp_hold_rd", 32'(bus.rd_o), 32'd1);
      idle();
      bus.out_ready_i = 1'b1;
      step();
      chk("bp_b_valid", 32'(bus.out_valid_o), 32'd1);
      chk("bp_b_rd", 32'(bus.rd_o), 32'd2);
      chk("bp_b_op_a", bus.op_a_o, 32'h0000_0010);
      chk("bp_ready_back", 32'(bus.in_ready_o), 32'd1);
      step();
      chk("bp_empty", 32'(bus.out_valid_o), 32'd0);

      // Streaming, no bubbles
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, (i % 2 == 1) ? 5'd5 : 5'd6, 5'd3,
               12'(i * 12'h155), i[0], i[1:0], 5'(16 + i));
         step();
         chk("strm_valid", 32'(bus.out_valid_o), 32'd1);
         chk("strm_rd", 32'(bus.rd_o), 32'(16 + i));
      end
      idle();
      step();
      chk("strm_end", 32'(bus.out_valid_o), 32'd0);

      // Flush while FULL; same-cycle write still commits
      bus.out_ready_i = 1'b0;
      drive(1'b1, 5'd5, 5'd0, 12'h0, 1'b0, 2'b00, 5'd20);
      step();
      drive(1'b1, 5'd6, 5'd0, 12'h0, 1'b0, 2'b00, 5'd21);
      step();
      chk("fl_full", 32'(bus.in_ready_o), 32'd0);
      drive(1'b1, 5'd3, 5'd0, 12'h0, 1'b0, 2'b00, 5'd22);
      flush = 1'b1;
      wb(1'b1, 5'd7, 32'h0000_0077);
      step();
      flush = 1'b0;
      wb(1'b0, 5'd0, 32'h0);
      idle();
      chk("fl_valid", 32'(bus.out_valid_o), 32'd0);
      chk("fl_ready", 32'(bus.in_ready_o), 32'd1);
      exp_q.delete();
      bus.out_ready_i = 1'b1;
      drive(1'b1, 5'd7, 5'd0, 12'h0, 1'b0, 2'b00, 5'd23);
      step();
      chk("fl_wb_commit", bus.op_a_o, 32'h0000_0077);
      idle();
      step();

      // Asynchronous reset mid-stream
      bus.out_ready_i = 1'b0;
      drive(1'b1, 5'd5, 5'd6, 12'h0, 1'b0, 2'b00, 5'd24);
      step();
      drive(1'b1, 5'd6, 5'd5, 12'h0, 1'b0, 2'b00, 5'd25);
      step();
      idle();
      #2;
      rst_n = 1'b0;
      #1;
      chk("ar_valid", 32'(bus.out_valid_o), 32'd0);
      chk("ar_op_a", bus.op_a_o, 32'h0);
      chk("ar_op_b", bus.op_b_o, 32'h0);
      chk("ar_rd", 32'(bus.rd_o), 32'd0);
      chk("ar_ready", 32'(bus.in_ready_o), 32'd1);
      exp_q.delete();
      for (int i = 0; i < 32; i++) mreg[i] = '0;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      bus.out_ready_i = 1'b1;
      drive(1'b1, 5'd5, 5'd5, 12'h0, 1'b0, 2'b00, 5'd26);
      step();
      chk("ar_x5_zero", bus.op_a_o, 32'h0);
      idle();
      step();
      chk("sb_drained", 32'(exp_q.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/cmp_operand_issue.md
Name: cmp_operand_issue

Overview:
- Operand issue stage directly upstream of the compare unit (SLT/SLTU/SLTI/SLTIU path).
- Holds the 32x32 integer register file and accepts decoded compare instructions over a valid/ready handshake.
- Reads rs1/rs2, with same-cycle write-back bypass, and selects the register or sign-extended immediate for operand B.
- Delivers op_a/op_b/opcode/rd to the compare unit through a registered output stage plus a 1-entry skid buffer.

Parameters:
- DATA_W, 32, operand and register width.
- REG_N, 32, number of architectural registers; x0 reads as zero.
- IMM_W, 12, immediate width, sign-extended to DATA_W.
- OP_SIGNED, 2'b00, compare opcode for signed less-than.
- OP_UNSIGNED, 2'b01, compare opcode for unsigned less-than.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_n_i  in  1  asynchronous, active-low reset.
- flush_i  in  1  synchronous; discards all held entries.
- in_valid_i  in  1  decoded instruction valid.
- in_ready_o  out  1  stage can accept an instruction.
- in_rs1_i  in  5  source register A.
- in_rs2_i  in  5  source register B.
- in_imm_i  in  IMM_W  immediate.
- in_use_imm_i  in  1  1 = operand B is the immediate.
- in_opcode_i  in  2  compare opcode, passed through.
- in_rd_i  in  5  destination, passed through.
- wb_we_i  in  1  register write enable.
- wb_addr_i  in  5  write address.
- wb_data_i  in  DATA_W  write data.
- out_valid_o  out  1  operands valid to compare unit.
- out_ready_i  in  1  consumer accepts this cycle.
- op_a_o  out  DATA_W  operand A.
- op_b_o  out  DATA_W  operand B.
- opcode_o  out  2  compare opcode.
- rd_o  out  5  destination.

Behaviour:
- Clock and reset: one clock (clk_i). Reset (rst_n_i) is asynchronous and active-low.
- Values on reset:
  - out_valid_o=0 and skid valid=0.
  - op_a_o/op_b_o=0, opcode_o=2'b00, rd_o=0.
  - All registers = 0.
  - in_ready_o=1, combinationally derived as !skid_valid.
- Register file:
  - A write occurs on a clock edge when wb_we_i=1 and wb_addr_i!=0.
  - Writes to x0 are ignored; reads of x0 return 0.
- Bypass:
  - If wb_we_i=1, wb_addr_i==rsN and rsN!=0, the read of rsN returns wb_data_i in the same cycle.
- Operand B:
  - in_use_imm_i=1: op_b = in_imm_i sign-extended (bit IMM_W-1 replicated).
  - in_use_imm_i=0: op_b = rs2 value.
- Opcodes: in_opcode_i and in_rd_i pass through unmodified. The compare unit handles undefined opcodes.
- Handshakes:
  - An input transfer occurs when in_valid_i && in_ready_o.
  - An output transfer occurs when out_valid_o && out_ready_i.
- Latency: 1 cycle from input transfer to out_valid_o when the output is empty or draining.
- Storage: output register (OUT) plus skid register (SKID). States by occupancy:
  - EMPTY:
    - Input transfer -> ONE (OUT loaded).
  - ONE:
    - Input transfer with output transfer -> ONE, OUT reloaded with the new entry.
    - Input transfer without output transfer -> FULL, new entry goes to SKID.
    - Output transfer without input transfer -> EMPTY.
  - FULL (in_ready_o=0):
    - Output transfer -> ONE, SKID moves to OUT.
    - No input is accepted in FULL.
- Operand capture:
  - Operands are read and bypassed at input-accept time.
  - Entries in SKID are not re-read. The decode/hazard logic upstream guarantees no RAW hazard against in-flight entries.
- Output stability:
  - While out_valid_o=1 and out_ready_i=0, op_a_o/op_b_o/opcode_o/rd_o hold stable.
- flush_i=1:
  - Next cycle out_valid_o=0 and SKID cleared, leaving the stage EMPTY.
  - Any input offered in the same cycle is dropped.
  - A wb write in the same cycle still commits.
- Reset mid-operation: all entries are discarded immediately. Register file contents return to 0.

Decomposition:
- Shared package cmp_pkg holds:
  - OP_SIGNED, OP_UNSIGNED and the compare result constants shared with the compare unit.
  - DATA_W and the REG_ADDR_W=5 constant.
  - A struct/bundle {op_a, op_b, opcode, rd} for the issue payload.
- One sub-module: cmp_regfile (2 asynchronous read ports with bypass, 1 synchronous write port, x0 hardwired, asynchronous active-low reset).
- The skid/occupancy logic stays in the top module.

Test Plan:
- Bypass and immediate path:
  - Stimulus: after reset, wb x5=0xFFFF_FFF0 and x6=0x0000_0010; issue rs1=5, rs2=6, use_imm=0, opcode=00, rd=7; out_ready=1.
  - Required: next cycle out_valid=1, op_a=0xFFFF_FFF0, op_b=0x10, opcode=00, rd=7.
  - Stimulus: issue with use_imm=1, imm=12'h800.
  - Required: op_b=0xFFFF_F800.
- Same-cycle bypass: wb_we=1, addr=3, data=0x1234 in the same cycle as issue rs1=3 -> op_a=0x1234.
- x0 handling: wb x0=0xDEAD, then issue rs1=0 -> op_a=0.
- Backpressure:
  - Stimulus: hold out_ready=0; issue A and B on consecutive cycles.
  - Required: in_ready=0 after B is accepted; a third issue C is not accepted; op_a holds A's value.
  - Stimulus: release out_ready.
  - Required: A then B delivered in order on consecutive cycles; in_ready returns to 1 the cycle after A drains.
- Streaming: out_ready=1 and in_valid=1 every cycle for 8 instructions -> 8 outputs on consecutive cycles, in order, no bubbles.
- Flush and reset:
  - flush_i asserted while FULL -> next cycle out_valid=0 and in_ready=1.
  - rst_n_i deasserted mid-stream -> outputs zero immediately; a read of x5 after reset returns 0.
